zet_pic_ng: RTL and testbench

Parametrised successor to the fixed 8-input master/slave 8259A pair, replacing the master/slave cascade with a single controller of NUM_IRQ inputs.
- Provides IRR/IMR/ISR/edge-level registers, fixed priority with nesting, specific and non-specific EOI, and an NMI latch.
- Sits on the CPU Wishbone switch as an I/O slave and drives the Zet intr/nmi tags (wb_tgc_o) directly.

---
 rtl/zet_pic_ng_pkg.sv | 38 +++
 rtl/zet_pic_prio_enc.sv | 24 ++
 rtl/zet_pic_ng.sv | 150 +++++++++++++++
 tb/tb_zet_pic_ng.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zet_pic_ng_pkg.sv
// Shared constants, types and bank helpers for the zet_pic_ng interrupt controller.
package zet_pic_ng_pkg;

  // Word register offsets (CPU adr[2:1])
  localparam logic [1:0] REG_CMD  = 2'd0;
  localparam logic [1:0] REG_IMR  = 2'd1;
  localparam logic [1:0] REG_ISR  = 2'd2;
  localparam logic [1:0] REG_ELCR = 2'd3;

  // Command word layout
  localparam int unsigned CMD_SPEC_BIT = 15;
  localparam int unsigned CMD_BANK_LSB = 13;
  localparam int unsigned CMD_IDX_W    = 5;

  localparam int unsigned BANK_W = 16;
  localparam int unsigned MAX_W  = 32;

  typedef logic [4:0] irq_idx_t;

  // Extract the 16-bit bank b of a register padded to 32 bits
  function automatic logic [BANK_W-1:0] bank_rd(input logic [MAX_W-1:0] v,
                                                input logic [1:0] b);
    bank_rd = BANK_W'(v >> {b, 4'd0});
  endfunction

  // Byte-masked write of bank b into a register padded to 32 bits
  function automatic logic [MAX_W-1:0] bank_wr(input logic [MAX_W-1:0]  v,
                                               input logic [1:0]        b,
                                               input logic [BANK_W-1:0] dat,
                                               input logic [1:0]        sel);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] data;
    mask    = MAX_W'({{8{sel[1]}}, {8{sel[0]}}}) << {b, 4'd0};
    data    = MAX_W'(dat) << {b, 4'd0};
    bank_wr = (v & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/zet_pic_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any bit is set and its index.
module zet_pic_prio_enc
  import zet_pic_ng_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] vec,
  output logic         valid_c,
  output irq_idx_t     idx_c
);

  // Scan from the top so the lowest set bit is the last assignment
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid_c = 1'b1;
        idx_c   = irq_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/zet_pic_ng.sv
// Parametrised single-level interrupt controller (8259A-style) on the Wishbone I/O switch.
// Optional macro ZET_PIC_AUTO_EOI_EN: INTA never sets ISR, EOI commands become no-ops.
module zet_pic_ng
  import zet_pic_ng_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 16,
  parameter logic [7:0]  VEC_BASE = 8'h08,
  parameter logic [31:0] IMR_RST  = 32'hFFFF_FFFB,
  parameter logic [31:0] ELCR_RST = 32'h0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               nmi_i,
  input  logic [1:0]         wb_adr_i,
  input  logic [15:0]        wb_dat_i,
  output logic [15:0]        wb_dat_o,
  input  logic [1:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  input  logic [1:0]         wb_tgc_i,
  output logic [1:0]         wb_tgc_o
);

  localparam logic [NUM_IRQ-1:0] IRQ_ONE  = NUM_IRQ'(1);
  localparam logic [7:0]         SPUR_VEC = 8'(VEC_BASE + 8'(NUM_IRQ - 1));

  logic [NUM_IRQ-1:0] irq_q, irr_q, imr_q, isr_q, elcr_q;
  logic [NUM_IRQ-1:0] irr_d, imr_d, isr_d, elcr_d;
  logic [NUM_IRQ-1:0] elig_c, below_c, cand_c, inta_clr_c;
  logic [1:0]         bank_q, bank_d;
  logic [15:0]        dat_q, dat_d;
  logic               nmi_q, nmi_lat_q, nmi_lat_d;
  logic               ack_q, blk_q, intr_q;
  logic               req_c, acc_c, inta_c, wr_c, cmd_c, spec_c;
  logic               win_v_c, isr_v_c;
  irq_idx_t           win_idx_c, isr_idx_c, eoi_idx_c;

  // Lowest in-service level bounds which requests may nest
  zet_pic_prio_enc #(.W(NUM_IRQ)) u_isr_enc (
    .vec     (isr_q),
    .valid_c (isr_v_c),
    .idx_c   (isr_idx_c)
  );

  // Highest-priority eligible request strictly above the in-service level
  zet_pic_prio_enc #(.W(NUM_IRQ)) u_win_enc (
    .vec     (cand_c),
    .valid_c (win_v_c),
    .idx_c   (win_idx_c)
  );

  // Priority masking
  always_comb begin
    elig_c  = irr_q & ~imr_q;
    below_c = isr_v_c ? ((IRQ_ONE << isr_idx_c) - IRQ_ONE) : '1;
    cand_c  = elig_c & below_c;
  end

  // Bus request decode; a transfer held across reset stays blocked until stb drops
  always_comb begin
    req_c      = wb_cyc_i & wb_stb_i;
    acc_c      = req_c & ~ack_q & ~blk_q;
    inta_c     = acc_c & wb_tgc_i[1] & ~wb_we_i;
    wr_c       = acc_c & wb_we_i;
    cmd_c      = wr_c & (wb_adr_i == REG_CMD) & (|wb_sel_i);
    spec_c     = wb_sel_i[1] & wb_dat_i[CMD_SPEC_BIT];
    eoi_idx_c  = irq_idx_t'(wb_dat_i[CMD_IDX_W-1:0] & {CMD_IDX_W{wb_sel_i[0]}});
    inta_clr_c = (inta_c & win_v_c) ? ((IRQ_ONE << win_idx_c) & ~elcr_q) : '0;
  end

  // Next-state for interrupt registers, bank select and read data
  always_comb begin
    irr_d     = (irr_q & ~inta_clr_c) | (irq_i & ~irq_q);
    irr_d     = (irr_d & ~elcr_q) | (irq_i & elcr_q);
    imr_d     = imr_q;
    elcr_d    = elcr_q;
    isr_d     = isr_q;
    bank_d    = bank_q;
    dat_d     = dat_q;
    nmi_lat_d = (nmi_i & ~nmi_q) | (nmi_lat_q & ~wb_tgc_i[0]);

    if (wr_c && wb_adr_i == REG_IMR)
      imr_d = NUM_IRQ'(bank_wr(MAX_W'(imr_q), bank_q, wb_dat_i, wb_sel_i));
    if (wr_c && wb_adr_i == REG_ELCR)
      elcr_d = NUM_IRQ'(bank_wr(MAX_W'(elcr_q), bank_q, wb_dat_i, wb_sel_i));
    if (cmd_c && wb_sel_i[1])
      bank_d = wb_dat_i[CMD_BANK_LSB +: 2];

`ifdef ZET_PIC_AUTO_EOI_EN
    isr_d = '0;
`else
    if (inta_c && win_v_c)
      isr_d = isr_q | (IRQ_ONE << win_idx_c);
    else if (cmd_c && spec_c)
      isr_d = isr_q & ~(IRQ_ONE << eoi_idx_c);
    else if (cmd_c && isr_v_c)
      isr_d = isr_q & ~(IRQ_ONE << isr_idx_c);
`endif

    if (inta_c) begin
      dat_d = {8'h00, win_v_c ? 8'(VEC_BASE + 8'(win_idx_c)) : SPUR_VEC};
    end else if (acc_c && !wb_we_i) begin
      unique case (wb_adr_i)
        REG_CMD:  dat_d = bank_rd(MAX_W'(irr_q), bank_q);
        REG_IMR:  dat_d = bank_rd(MAX_W'(imr_q), bank_q);
        REG_ISR:  dat_d = bank_rd(MAX_W'(isr_q), bank_q);
        default:  dat_d = bank_rd(MAX_W'(elcr_q), bank_q);
      endcase
    end
  end

  // State registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_q     <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      imr_q     <= NUM_IRQ'(IMR_RST);
      elcr_q    <= NUM_IRQ'(ELCR_RST);
      bank_q    <= '0;
      dat_q     <= '0;
      nmi_q     <= 1'b0;
      nmi_lat_q <= 1'b0;
      ack_q     <= 1'b0;
      blk_q     <= 1'b1;
      intr_q    <= 1'b0;
    end else begin
      irq_q     <= irq_i;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      elcr_q    <= elcr_d;
      bank_q    <= bank_d;
      dat_q     <= dat_d;
      nmi_q     <= nmi_i;
      nmi_lat_q <= nmi_lat_d;
      ack_q     <= acc_c;
      blk_q     <= blk_q & req_c;
      intr_q    <= win_v_c;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_tgc_o = {intr_q, nmi_lat_q};

endmodule

// File: tb/tb_zet_pic_ng.sv
// Scoreboard bench for zet_pic_ng (NUM_IRQ=16, VEC_BASE=8'h08).
module tb_zet_pic_ng;
  import zet_pic_ng_pkg::*;

  localparam int unsigned NUM_IRQ = 16;

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_n_i;
  logic [NUM_IRQ-1:0] irq_i;
  logic               nmi_i;
  logic [1:0]         wb_adr_i;
  logic [15:0]        wb_dat_i;
  logic [15:0]        wb_dat_o;
  logic [1:0]         wb_sel_i;
  logic               wb_we_i;
  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic               wb_ack_o;
  logic [1:0]         wb_tgc_i;
  logic [1:0]         wb_tgc_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_dat_q[$];
  string       exp_tag_q[$];

  zet_pic_ng #(.NUM_IRQ(NUM_IRQ)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .irq_i      (irq_i),
    .nmi_i      (nmi_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_ack_o   (wb_ack_o),
    .wb_tgc_i   (wb_tgc_i),
    .wb_tgc_o   (wb_tgc_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // One Wishbone transfer; reads push their expectation and pop it on ack
  task automatic bus_cyc(input logic [1:0] adr, input logic we, input logic [15:0] dat,
                         input logic [1:0] sel, input logic [1:0] tgc,
                         input string tag, input logic [15:0] exp);
    bit got_ack;
    got_ack  = 1'b0;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_tgc_i = tgc;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    if (!we) begin
      exp_dat_q.push_back(exp);
      exp_tag_q.push_back(tag);
    end
    for (int i = 0; i < 6 && !got_ack; i++) begin
      tick(1);
      if (wb_ack_o) got_ack = 1'b1;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_tgc_i = 2'b00;
    if (!got_ack) begin
      check_eq({tag, "_ack_timeout"}, 32'd0, 32'd1);
      if (!we) begin
        void'(exp_dat_q.pop_front());
        void'(exp_tag_q.pop_front());
      end
    end else if (!we) begin
      logic [15:0] e;
      string       t;
      e = exp_dat_q.pop_front();
      t = exp_tag_q.pop_front();
      check_eq(t, 32'(wb_dat_o), 32'(e));
    end
  endtask

  task automatic bus_wr(input logic [1:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    bus_cyc(adr, 1'b1, dat, sel, 2'b00, "wr", 16'h0000);
  endtask

  task automatic bus_rd(input logic [1:0] adr, input string tag, input logic [15:0] exp);
    bus_cyc(adr, 1'b0, 16'h0000, 2'b11, 2'b00, tag, exp);
  endtask

  task automatic inta(input string tag, input logic [15:0] exp);
    bus_cyc(REG_CMD, 1'b0, 16'h0000, 2'b11, 2'b10, tag, exp);
  endtask

  task automatic pulse_irq(input logic [NUM_IRQ-1:0] m);
    irq_i = irq_i | m;
    tick(1);
    irq_i = irq_i & ~m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_n_i = 1'b1;
    irq_i      = '0;
    nmi_i      = 1'b0;
    wb_adr_i   = 2'd0;
    wb_dat_i   = 16'h0000;
    wb_sel_i   = 2'b00;
    wb_we_i    = 1'b0;
    wb_cyc_i   = 1'b0;
    wb_stb_i   = 1'b0;
    wb_tgc_i   = 2'b00;

    // Reset with a transfer pending: nothing acked during or after it
    #1 wb_rst_n_i = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick(2);
    check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
    check_eq("rst_tgc", 32'(wb_tgc_o), 32'd0);
    check_eq("rst_dat", 32'(wb_dat_o), 32'd0);
    wb_rst_n_i = 1'b1;
    tick(1);
    check_eq("abort_ack0", 32'(wb_ack_o), 32'd0);
    tick(1);
    check_eq("abort_ack1", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick(1);

    bus_rd(REG_IMR,  "imr_rst",  16'hFFFB);
    bus_rd(REG_ELCR, "elcr_rst", 16'h0000);
    bus_rd(REG_ISR,  "isr_rst",  16'h0000);

    // Bank 1 is beyond NUM_IRQ and reads zero
    bus_wr(REG_CMD, 16'h2000, 2'b11);
    bus_rd(REG_IMR, "imr_bank1", 16'h0000);
    bus_wr(REG_CMD, 16'h0000, 2'b11);
    bus_rd(REG_IMR, "imr_bank0", 16'hFFFB);

    // Edge IRQ3: intr two cycles after the input edge
    bus_wr(REG_IMR, 16'h0000, 2'b11);
    irq_i[3] = 1'b1;
    tick(1);
    check_eq("intr_lat1", 32'(wb_tgc_o[1]), 32'd0);
    irq_i[3] = 1'b0;
    tick(1);
    check_eq("intr_lat2", 32'(wb_tgc_o[1]), 32'd1);
    inta("inta_irq3", 16'h000B);
    bus_rd(REG_ISR, "isr_irq3", 16'h0008);
    bus_rd(REG_CMD, "irr_irq3", 16'h0000);
    check_eq("intr_after_inta", 32'(wb_tgc_o[1]), 32'd0);
    bus_wr(REG_CMD, 16'h8013, 2'b11);
    bus_rd(REG_ISR, "isr_eoi_oob", 16'h0008);
    bus_wr(REG_ISR, 16'hFFFF, 2'b11);
    bus_rd(REG_ISR, "isr_ro", 16'h0008);
    bus_wr(REG_CMD, 16'h0000, 2'b11);
    bus_rd(REG_ISR, "isr_ns_eoi", 16'h0000);

    // Nesting: IRQ5 in service, IRQ2 preempts, IRQ7 waits for two EOIs
    pulse_irq(16'h0020);
    tick(1);
    inta("inta_irq5", 16'h000D);
    pulse_irq(16'h0084);
    tick(1);
    check_eq("intr_nest", 32'(wb_tgc_o[1]), 32'd1);
    inta("inta_irq2", 16'h000A);
    bus_rd(REG_ISR, "isr_nest", 16'h0024);
    check_eq("irq7_blk_a", 32'(wb_tgc_o[1]), 32'd0);
    bus_wr(REG_CMD, 16'h0000, 2'b11);
    bus_rd(REG_ISR, "isr_eoi1", 16'h0020);
    tick(1);
    check_eq("irq7_blk_b", 32'(wb_tgc_o[1]), 32'd0);
    bus_wr(REG_CMD, 16'h0000, 2'b11);
    tick(2);
    check_eq("irq7_free", 32'(wb_tgc_o[1]), 32'd1);
    inta("inta_irq7", 16'h000F);
    bus_wr(REG_CMD, 16'h8007, 2'b11);
    bus_rd(REG_ISR, "isr_spec_eoi", 16'h0000);

    // Level IRQ4 held: re-requests after EOI
    bus_wr(REG_ELCR, 16'h0010, 2'b11);
    irq_i[4] = 1'b1;
    tick(2);
    check_eq("intr_lvl", 32'(wb_tgc_o[1]), 32'd1);
    inta("inta_lvl_a", 16'h000C);
    tick(1);
    check_eq("intr_lvl_isr", 32'(wb_tgc_o[1]), 32'd0);
    bus_rd(REG_CMD, "irr_lvl", 16'h0010);
    bus_wr(REG_CMD, 16'h0000, 2'b11);
    tick(2);
    check_eq("intr_lvl_re", 32'(wb_tgc_o[1]), 32'd1);
    inta("inta_lvl_b", 16'h000C);
    bus_wr(REG_CMD, 16'h0000, 2'b11);
    irq_i[4] = 1'b0;
    tick(2);
    bus_rd(REG_CMD, "irr_lvl_drop", 16'h0000);
    check_eq("intr_lvl_drop", 32'(wb_tgc_o[1]), 32'd0);
    bus_wr(REG_ELCR, 16'h0000, 2'b11);

    // Byte selects on IMR, then spurious INTA with everything masked
    bus_wr(REG_IMR, 16'hFFFF, 2'b01);
    bus_rd(REG_IMR, "imr_lo_byte", 16'h00FF);
    bus_wr(REG_IMR, 16'hFFFF, 2'b10);
    bus_rd(REG_IMR, "imr_hi_byte", 16'hFFFF);
    pulse_irq(16'h0040);
    tick(1);
    check_eq("intr_masked", 32'(wb_tgc_o[1]), 32'd0);
    inta("inta_spur", 16'h0017);
    bus_rd(REG_ISR, "isr_spur", 16'h0000);
    bus_rd(REG_CMD, "irr_spur", 16'h0040);
    bus_wr(REG_IMR, 16'h0000, 2'b11);
    tick(2);
    check_eq("intr_unmask", 32'(wb_tgc_o[1]), 32'd1);
    inta("inta_irq6", 16'h000E);
    bus_wr(REG_CMD, 16'h0000, 2'b11);
    bus_rd(REG_ISR, "isr_final", 16'h0000);

    // NMI latch: set by edge, cleared by nmia, a coincident edge wins
    nmi_i = 1'b1;
    tick(1);
    check_eq("nmi_set", 32'(wb_tgc_o[0]), 32'd1);
    tick(1);
    check_eq("nmi_hold", 32'(wb_tgc_o[0]), 32'd1);
    wb_tgc_i = 2'b01;
    tick(1);
    wb_tgc_i = 2'b00;
    check_eq("nmi_clr", 32'(wb_tgc_o[0]), 32'd0);
    nmi_i = 1'b0;
    tick(1);
    nmi_i    = 1'b1;
    wb_tgc_i = 2'b01;
    tick(1);
    wb_tgc_i = 2'b00;
    check_eq("nmi_edge_wins", 32'(wb_tgc_o[0]), 32'd1);
    nmi_i = 1'b0;
    tick(1);
    check_eq("nmi_latched", 32'(wb_tgc_o[0]), 32'd1);
    wb_tgc_i = 2'b01;
    tick(1);
    wb_tgc_i = 2'b00;
    check_eq("nmi_clr2", 32'(wb_tgc_o[0]), 32'd0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
